fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register; sits directly upstream of the instruction decoder/controller and feeds it `id_inst`.
- Holds the PC and drives the instruction ROM address; receives its inst combinationally.
- Applies resolved control-flow redirects from EX (branch/JAL/JALR), using the shared NPC op encoding, and applies hazard stalls.
- Flushes wrong-path instructions and tells downstream to bubble ID/EX.

Parameters:
- PC_W, 32, PC/address/instruction width.
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- NOP_INST, 32'h0000_0013, bubble instruction (addi x0,x0,0) inserted on flush/reset.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- irom_addr  out  PC_W  fetch address, combinational = pc.
- irom_inst  in  PC_W  instruction at irom_addr, same cycle.
- stall  in  1  hazard unit: hold PC and IF/ID.
- ex_npc_op  in  2  NPC op of the instruction in EX (NPC_PC4/NPC_JMP/NPC_JAL/NPC_JALR).
- ex_br_taken  in  1  branch comparison result from EX.
- ex_pc  in  PC_W  PC of the instruction in EX.
- ex_imm  in  PC_W  sign-extended immediate of the instruction in EX.
- ex_alu_c  in  PC_W  ALU result (rs1+imm) for JALR.
- id_inst  out  PC_W  registered instruction to the controller.
- id_pc  out  PC_W  registered PC of id_inst.
- id_pc4  out  PC_W  id_pc+4.
- id_valid  out  1  id_inst is a real instruction (0 = bubble).
- flush_o  out  1  combinational; 1 in a redirect cycle; downstream bubbles ID/EX next edge.
- perf_fetch_cnt  out  32  instructions accepted into ID (optional feature).
- perf_flush_cnt  out  32  redirect count (optional feature).

Behaviour:
- Reset values: pc=RESET_PC, id_inst=NOP_INST, id_pc=0, id_pc4=4, id_valid=0, perf counters=0. Reset overrides stall and redirect. Reset mid-operation discards everything in flight.
- Redirect is asserted when ex_npc_op==NPC_JAL, or NPC_JALR, or (NPC_JMP && ex_br_taken). NPC_PC4 and any undefined encoding mean no redirect.
- Redirect targets, all mod 2^PC_W with silent wrap:
  - JMP/JAL: ex_pc+ex_imm.
  - JALR: ex_alu_c with bit0 cleared.
  - No misalignment trap.
- Priority per cycle, highest first: rst > redirect > stall > normal.
  - Redirect: pc<=target; IF/ID <= {NOP_INST, id_valid=0}; flush_o=1. Applies even when stall=1; a stall from the wrong path is ignored.
  - Stall, no redirect: pc and all IF/ID registers hold; flush_o=0.
  - Normal: pc<=pc+4; IF/ID <= {irom_inst, pc, pc+4, valid=1}.
- Latency:
  - Fetch-to-ID is 1 cycle.
  - Taken control flow costs 2 bubbles: the IF instruction is killed by this block; the ID instruction is killed downstream via flush_o.
  - Target inst appears on id_inst 2 edges after the redirect cycle.
- pc+4 wraps from 32'hFFFF_FFFC to 0.
- No internal state machine beyond pc and the valid bit. A flush followed by a stall holds the bubble (id_valid stays 0).

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- Defined:
  - perf_fetch_cnt increments on each normal-update edge (valid instr written to IF/ID).
  - perf_flush_cnt increments on each redirect edge.
  - Both are 32-bit, wrap, and reset to 0.
- Undefined: both ports are tied to 0 and no counter flops are generated.

Decomposition:
- Shared header (defines.vh): NPC_PC4/NPC_JMP/NPC_JAL/NPC_JALR encodings, NOP_INST value, and the RESET_PC default, shared with the controller and EX.
- One natural sub-module, fetch_npc:
  - Combinational.
  - Inputs: pc, ex_npc_op, ex_br_taken, ex_pc, ex_imm, ex_alu_c.
  - Outputs: npc and redirect.
- The fetch_stage top holds pc, the IF/ID registers, priority logic and counters.

Test Plan:
- Reset, then 3 free-running cycles with irom returning addr-tagged words → irom_addr 0,4,8; id_pc 0,4 with id_valid=1 after 1 edge; id_inst matches.
- Taken BEQ (ex_npc_op=NPC_JMP, br_taken=1, ex_pc=0x10, ex_imm=0xFFFF_FFF8) → flush_o=1, next pc=0x08, id_inst=0x0000_0013/id_valid=0; BEQ with br_taken=0 → no flush, pc+4.
- JALR ex_alu_c=0x0000_0103 → next pc=0x0000_0102; JAL ex_pc=0x20, ex_imm=0x40 → pc=0x60.
- Stall held 3 cycles at pc=0x0C → irom_addr, id_inst, id_pc unchanged; release → resumes 0x10. Stall and JAL same cycle → redirect wins.
- rst asserted mid-stream with a concurrent redirect → pc=RESET_PC, id_valid=0 next edge; pc=0xFFFF_FFFC normal → wraps to 0.
- FETCH_PERF_CNT_EN defined: 10 fetches, 2 redirects, 1 stall cycle → perf_fetch_cnt=10, perf_flush_cnt=2; undefined → both read 0.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// Shared fetch/control definitions: NPC op encodings, bubble instruction and
// the default reset PC. Imported by fetch_stage, fetch_npc, the controller and EX.
package fetch_stage_pkg;

  localparam int PC_W_DEF = 32;

  // Next-PC operation carried down the pipe with each instruction
  typedef enum logic [1:0] {
    NPC_PC4  = 2'd0,
    NPC_JMP  = 2'd1,
    NPC_JAL  = 2'd2,
    NPC_JALR = 2'd3
  } npc_op_e;

  // addi x0,x0,0
  localparam logic [31:0] NOP_INST_DEF = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

endpackage

// File: rtl/fetch_npc.sv
// Combinational next-PC unit: decides whether the instruction in EX redirects
// fetch and computes the next fetch address (target or pc+4).
module fetch_npc
  import fetch_stage_pkg::*;
#(
  parameter int PC_W = PC_W_DEF
) (
  input  logic [PC_W-1:0] i_pc,
  input  logic [1:0]      i_ex_npc_op,
  input  logic            i_ex_br_taken,
  input  logic [PC_W-1:0] i_ex_pc,
  input  logic [PC_W-1:0] i_ex_imm,
  input  logic [PC_W-1:0] i_ex_alu_c,
  output logic [PC_W-1:0] o_npc,
  output logic            o_redirect
);

  // Select sequential fetch unless EX resolves a taken control transfer
  always_comb begin
    o_redirect = 1'b0;
    o_npc      = i_pc + PC_W'(4);
    case (npc_op_e'(i_ex_npc_op))
      NPC_JMP: begin
        if (i_ex_br_taken) begin
          o_redirect = 1'b1;
          o_npc      = i_ex_pc + i_ex_imm;
        end
      end
      NPC_JAL: begin
        o_redirect = 1'b1;
        o_npc      = i_ex_pc + i_ex_imm;
      end
      NPC_JALR: begin
        // Target LSB is always dropped; no misalignment trap is raised
        o_redirect = 1'b1;
        o_npc      = i_ex_alu_c & ~PC_W'(1);
      end
      default: begin
        o_redirect = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage with IF/ID pipeline register.
// Priority each cycle: rst > redirect > stall > normal fetch.
// Optional performance counters are built only when FETCH_PERF_CNT_EN is defined;
// otherwise perf_fetch_cnt / perf_flush_cnt are tied to zero.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int              PC_W     = PC_W_DEF,
  parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEF,
  parameter logic [PC_W-1:0] NOP_INST = NOP_INST_DEF
) (
  input  logic            clk,
  input  logic            rst,
  output logic [PC_W-1:0] irom_addr,
  input  logic [PC_W-1:0] irom_inst,
  input  logic            stall,
  input  logic [1:0]      ex_npc_op,
  input  logic            ex_br_taken,
  input  logic [PC_W-1:0] ex_pc,
  input  logic [PC_W-1:0] ex_imm,
  input  logic [PC_W-1:0] ex_alu_c,
  output logic [PC_W-1:0] id_inst,
  output logic [PC_W-1:0] id_pc,
  output logic [PC_W-1:0] id_pc4,
  output logic            id_valid,
  output logic            flush_o,
  output logic [31:0]     perf_fetch_cnt,
  output logic [31:0]     perf_flush_cnt
);

  logic [PC_W-1:0] r_pc;
  logic [PC_W-1:0] r_id_inst;
  logic [PC_W-1:0] r_id_pc;
  logic [PC_W-1:0] r_id_pc4;
  logic            r_id_valid;
  logic [PC_W-1:0] w_npc;
  logic [PC_W-1:0] w_pc4;
  logic            w_redirect;

  fetch_npc #(
    .PC_W (PC_W)
  ) u_npc (
    .i_pc          (r_pc),
    .i_ex_npc_op   (ex_npc_op),
    .i_ex_br_taken (ex_br_taken),
    .i_ex_pc       (ex_pc),
    .i_ex_imm      (ex_imm),
    .i_ex_alu_c    (ex_alu_c),
    .o_npc         (w_npc),
    .o_redirect    (w_redirect)
  );

  assign w_pc4     = r_pc + PC_W'(4);
  assign irom_addr = r_pc;
  assign flush_o   = w_redirect;
  assign id_inst   = r_id_inst;
  assign id_pc     = r_id_pc;
  assign id_pc4    = r_id_pc4;
  assign id_valid  = r_id_valid;

  // PC and IF/ID update; a redirect kills the IF instruction even during a stall
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc       <= RESET_PC;
      r_id_inst  <= NOP_INST;
      r_id_pc    <= '0;
      r_id_pc4   <= PC_W'(4);
      r_id_valid <= 1'b0;
    end else if (w_redirect) begin
      r_pc       <= w_npc;
      r_id_inst  <= NOP_INST;
      r_id_valid <= 1'b0;
    end else if (!stall) begin
      r_pc       <= w_npc;
      r_id_inst  <= irom_inst;
      r_id_pc    <= r_pc;
      r_id_pc4   <= w_pc4;
      r_id_valid <= 1'b1;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_fetch_cnt;
  logic [31:0] r_flush_cnt;

  // Count accepted fetches and redirects; both wrap silently
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_cnt <= '0;
      r_flush_cnt <= '0;
    end else if (w_redirect) begin
      r_flush_cnt <= r_flush_cnt + 32'd1;
    end else if (!stall) begin
      r_fetch_cnt <= r_fetch_cnt + 32'd1;
    end
  end

  assign perf_fetch_cnt = r_fetch_cnt;
  assign perf_flush_cnt = r_flush_cnt;
`else
  assign perf_fetch_cnt = 32'd0;
  assign perf_flush_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed testbench for fetch_stage. The instruction ROM is modelled as an
// address-tagged word so id_inst can be predicted from the fetch address.
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  localparam logic [31:0] TAG = 32'hA5A5_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] irom_addr;
  logic [31:0] irom_inst;
  logic        stall;
  logic [1:0]  ex_npc_op;
  logic        ex_br_taken;
  logic [31:0] ex_pc;
  logic [31:0] ex_imm;
  logic [31:0] ex_alu_c;
  logic [31:0] id_inst;
  logic [31:0] id_pc;
  logic [31:0] id_pc4;
  logic        id_valid;
  logic        flush_o;
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_flush_cnt;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  assign irom_inst = irom_addr ^ TAG;

  fetch_stage dut (
    .clk            (clk),
    .rst            (rst),
    .irom_addr      (irom_addr),
    .irom_inst      (irom_inst),
    .stall          (stall),
    .ex_npc_op      (ex_npc_op),
    .ex_br_taken    (ex_br_taken),
    .ex_pc          (ex_pc),
    .ex_imm         (ex_imm),
    .ex_alu_c       (ex_alu_c),
    .id_inst        (id_inst),
    .id_pc          (id_pc),
    .id_pc4         (id_pc4),
    .id_valid       (id_valid),
    .flush_o        (flush_o),
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_flush_cnt (perf_flush_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_perf(input string tag, input logic [31:0] f, input logic [31:0] r);
`ifdef FETCH_PERF_CNT_EN
    check({tag, "_fetch"}, perf_fetch_cnt, f);
    check({tag, "_flush"}, perf_flush_cnt, r);
`else
    check({tag, "_fetch"}, perf_fetch_cnt, 32'd0);
    check({tag, "_flush"}, perf_flush_cnt, 32'd0);
    if (f === r) n_checks += 0;
`endif
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; ex_npc_op = NPC_PC4; ex_br_taken = 1'b0;
    ex_pc = '0; ex_imm = '0; ex_alu_c = '0;
    step(); step();
    check("rst_addr", irom_addr, 32'h0);
    check("rst_inst", id_inst, NOP);
    check("rst_pc", id_pc, 32'h0);
    check("rst_pc4", id_pc4, 32'h4);
    check("rst_valid", {31'd0, id_valid}, 32'd0);
    check("rst_flush", {31'd0, flush_o}, 32'd0);
    check_perf("rst_perf", 32'd0, 32'd0);
    rst = 1'b0;
    #1;
    $display("txn reset: irom_addr=%08h id_valid=%0d", irom_addr, id_valid);

    // Three free-running fetches
    step();
    check("f1_addr", irom_addr, 32'h4);
    check("f1_pc", id_pc, 32'h0);
    check("f1_inst", id_inst, 32'h0 ^ TAG);
    check("f1_valid", {31'd0, id_valid}, 32'd1);
    $display("txn fetch: id_pc=%08h id_inst=%08h", id_pc, id_inst);
    step();
    check("f2_addr", irom_addr, 32'h8);
    check("f2_pc", id_pc, 32'h4);
    check("f2_pc4", id_pc4, 32'h8);
    $display("txn fetch: id_pc=%08h id_inst=%08h", id_pc, id_inst);
    step();
    check("f3_addr", irom_addr, 32'hC);
    check("f3_inst", id_inst, 32'h8 ^ TAG);
    $display("txn fetch: id_pc=%08h id_inst=%08h", id_pc, id_inst);

    // Stall for three cycles at pc=0x0C
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_addr", irom_addr, 32'hC);
      check("stall_pc", id_pc, 32'h8);
      check("stall_inst", id_inst, 32'h8 ^ TAG);
      $display("txn stall %0d: irom_addr=%08h id_pc=%08h", i, irom_addr, id_pc);
    end
    stall = 1'b0;
    step();
    check("resume_addr", irom_addr, 32'h10);
    check("resume_pc", id_pc, 32'hC);
    $display("txn resume: irom_addr=%08h", irom_addr);

    // Taken branch: 0x10 + (-8) = 0x08
    ex_npc_op = NPC_JMP; ex_br_taken = 1'b1; ex_pc = 32'h10; ex_imm = 32'hFFFF_FFF8;
    #1;
    check("beq_flush", {31'd0, flush_o}, 32'd1);
    step();
    check("beq_addr", irom_addr, 32'h8);
    check("beq_inst", id_inst, NOP);
    check("beq_valid", {31'd0, id_valid}, 32'd0);
    $display("txn beq taken: irom_addr=%08h id_valid=%0d", irom_addr, id_valid);

    // Not-taken branch: sequential
    ex_br_taken = 1'b0;
    #1;
    check("bnt_flush", {31'd0, flush_o}, 32'd0);
    step();
    check("bnt_addr", irom_addr, 32'hC);
    check("bnt_pc", id_pc, 32'h8);
    check("bnt_valid", {31'd0, id_valid}, 32'd1);
    $display("txn beq not-taken: irom_addr=%08h", irom_addr);

    // JALR clears bit 0
    ex_npc_op = NPC_JALR; ex_alu_c = 32'h0000_0103;
    step();
    check("jalr_addr", irom_addr, 32'h102);
    check("jalr_valid", {31'd0, id_valid}, 32'd0);
    $display("txn jalr: irom_addr=%08h", irom_addr);

    // JAL concurrent with stall: redirect wins
    ex_npc_op = NPC_JAL; ex_pc = 32'h20; ex_imm = 32'h40; stall = 1'b1;
    step();
    check("jal_addr", irom_addr, 32'h60);
    check("jal_valid", {31'd0, id_valid}, 32'd0);
    $display("txn jal+stall: irom_addr=%08h", irom_addr);

    // Stall after flush keeps the bubble
    ex_npc_op = NPC_PC4;
    step();
    check("bub_addr", irom_addr, 32'h60);
    check("bub_valid", {31'd0, id_valid}, 32'd0);
    check("bub_inst", id_inst, NOP);
    stall = 1'b0;
    step();
    check("tgt_addr", irom_addr, 32'h64);
    check("tgt_pc", id_pc, 32'h60);
    check("tgt_inst", id_inst, 32'h60 ^ TAG);
    check("tgt_valid", {31'd0, id_valid}, 32'd1);
    check_perf("mid_perf", 32'd6, 32'd3);
    $display("txn target: id_pc=%08h id_inst=%08h", id_pc, id_inst);

    // Reset with a concurrent redirect
    rst = 1'b1; ex_npc_op = NPC_JAL;
    step();
    check("rr_addr", irom_addr, 32'h0);
    check("rr_valid", {31'd0, id_valid}, 32'd0);
    check("rr_inst", id_inst, NOP);
    check("rr_pc4", id_pc4, 32'h4);
    check_perf("rr_perf", 32'd0, 32'd0);
    rst = 1'b0;
    $display("txn reset+redirect: irom_addr=%08h", irom_addr);

    // Jump to the top of the address space, then wrap
    ex_npc_op = NPC_JALR; ex_alu_c = 32'hFFFF_FFFD;
    step();
    check("top_addr", irom_addr, 32'hFFFF_FFFC);
    ex_npc_op = NPC_PC4;
    step();
    check("wrap_addr", irom_addr, 32'h0);
    check("wrap_pc", id_pc, 32'hFFFF_FFFC);
    check("wrap_pc4", id_pc4, 32'h0);
    check("wrap_valid", {31'd0, id_valid}, 32'd1);
    check_perf("end_perf", 32'd1, 32'd1);
    $display("txn wrap: irom_addr=%08h id_pc4=%08h", irom_addr, id_pc4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
